// File: rtl/rv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rv_rr_arbiter
//
// Round-robin arbiter sharing one execution resource (functional unit, memory
// port, ...) among N requesters. The request mask is rotated by a priority
// pointer and the first set bit of the rotated mask wins. The winner is held
// in a registered grant offered with a valid/ready handshake. The requester
// may optionally lock the resource across a multi-beat transfer.
//
// Ports
//   clk             in   clock, all state on rising edge
//   reset_n         in   asynchronous active-low reset
//   req_i           in   [N-1:0]     request mask, bit i = requester i
//   lock_i          in   sampled only on the handshake cycle; 1 = hold resource
//   unlock_i        in   single-cycle pulse releasing a locked resource
//   grant_ready_i   in   shared unit accepts the current grant
//   grant_valid_o   out  grant offered
//   grant_index_o   out  [LOGN-1:0]  winner index
//   grant_onehot_o  out  [N-1:0]     one-hot winner, zero when no grant held
//   busy_o          out  resource locked to grant_index_o
//
// All outputs come straight from flops. No combinational input-to-output path.
// -----------------------------------------------------------------------------
module rv_rr_arbiter #(
   parameter int N    = 8,
   parameter int LOGN = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N-1:0]    req_i,
   input  logic            lock_i,
   input  logic            unlock_i,
   input  logic            grant_ready_i,
   output logic            grant_valid_o,
   output logic [LOGN-1:0] grant_index_o,
   output logic [N-1:0]    grant_onehot_o,
   output logic            busy_o
);

   // N at LOGN+1 bits, the width used for modulo reduction of pointer sums.
   localparam logic [LOGN:0] N_W = (LOGN+1)'(N);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OFFER,
      ST_LOCKED
   } state_e;

   state_e          state_q;
   logic [LOGN-1:0] ptr_q;
   logic [LOGN-1:0] index_q;
   logic [N-1:0]    onehot_q;
   logic            valid_q;
   logic            busy_q;

   logic            any_req;
   logic            handshake;
   logic [LOGN:0]   inc_w;
   logic [LOGN-1:0] ptr_inc;
   logic [LOGN-1:0] sel_ptr;
   logic [N-1:0]    rot;
   logic [LOGN-1:0] cnt;
   logic [LOGN:0]   sum_w;
   logic [LOGN-1:0] win;
   logic [N-1:0]    win_onehot;

   assign any_req   = |req_i;
   assign handshake = valid_q & grant_ready_i;

   // Pointer that follows the current grant: (index + 1) mod N.
   assign inc_w   = {1'b0, index_q} + (LOGN+1)'(1);
   assign ptr_inc = (inc_w >= N_W) ? '0 : inc_w[LOGN-1:0];

   // In OFFER a reselect happens only on a handshake, and it must already use
   // the pointer that handshake produces, so back-to-back grants keep rotating.
   // In IDLE the stored pointer is the reference.
   assign sel_ptr = (state_q == ST_OFFER) ? ptr_inc : ptr_q;

   // Rotate so that requester sel_ptr sits at bit 0.
   assign rot = N'({req_i, req_i} >> sel_ptr);

   // Trailing-zero count of the rotated mask. Scanning from the top down lets
   // the lowest set bit overwrite earlier hits.
   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      cnt = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) cnt = LOGN'(i);
      end
   end

   // win = (sel_ptr + cnt) mod N. Both operands are < N, so one conditional
   // subtraction is enough. This also holds for a non-power-of-two N.
   always_comb begin
      sum_w = {1'b0, sel_ptr} + {1'b0, cnt};
      if (sum_w >= N_W) win = LOGN'(sum_w - N_W);
      else              win = sum_w[LOGN-1:0];
   end

   assign win_onehot = N'(1) << win;

   // Single FSM process. Every output register is updated here together with
   // the state, so outputs change only on the clock edge (or on reset).
   // NOTE: sequential state uses non-blocking assignments only. All flops then
   // sample pre-edge values and the block has no ordering dependence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         index_q  <= '0;
         onehot_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  index_q  <= win;
                  onehot_q <= win_onehot;
                  valid_q  <= 1'b1;
                  state_q  <= ST_OFFER;
               end
            end

            // The grant is sticky. It is not retracted if the winner's request
            // drops, and it only moves on a handshake.
            ST_OFFER: begin
               if (handshake) begin
                  ptr_q <= ptr_inc;
                  if (lock_i) begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= ST_LOCKED;
                  end else if (any_req) begin
                     index_q  <= win;
                     onehot_q <= win_onehot;
                  end else begin
                     valid_q  <= 1'b0;
                     onehot_q <= '0;
                     state_q  <= ST_IDLE;
                  end
               end
            end

            // Resource is owned by index_q. Requests are ignored until released.
            ST_LOCKED: begin
               if (unlock_i) begin
                  busy_q   <= 1'b0;
                  onehot_q <= '0;
                  state_q  <= ST_IDLE;
               end
            end

            default: begin
               valid_q  <= 1'b0;
               busy_q   <= 1'b0;
               onehot_q <= '0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant_valid_o  = valid_q;
   assign grant_index_o  = index_q;
   assign grant_onehot_o = onehot_q;
   assign busy_o         = busy_q;

   // Structural invariants of the registered outputs.
   a_valid_busy_excl : assert property (@(posedge clk) disable iff (!reset_n)
      !(valid_q && busy_q));

   a_onehot_match : assert property (@(posedge clk) disable iff (!reset_n)
      (valid_q || busy_q) |-> (onehot_q == (N'(1) << index_q)));

   a_onehot_idle : assert property (@(posedge clk) disable iff (!reset_n)
      (!valid_q && !busy_q) |-> (onehot_q == '0));

   a_index_range : assert property (@(posedge clk) disable iff (!reset_n)
      ({1'b0, index_q} < N_W) && ({1'b0, ptr_q} < N_W));

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv_rr_arbiter
//
// Bench for rv_rr_arbiter. It uses an 8-requester instance for the main
// sequences and a 6-requester instance for pointer wrap with a non-power-of-two
// N. Each step drives one cycle of inputs and pushes the outputs expected after
// the next rising edge onto a scoreboard queue. The entry is popped and
// compared 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_rv_rr_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // N = 8 instance
   logic [7:0] req8;
   logic       lock8, unlock8, ready8;
   logic       v8, busy8;
   logic [2:0] idx8;
   logic [7:0] oh8;

   // N = 6 instance
   logic [5:0] req6;
   logic       lock6, unlock6, ready6;
   logic       v6, busy6;
   logic [2:0] idx6;
   logic [5:0] oh6;

   rv_rr_arbiter #(.N(8)) u8 (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_i          (req8),
      .lock_i         (lock8),
      .unlock_i       (unlock8),
      .grant_ready_i  (ready8),
      .grant_valid_o  (v8),
      .grant_index_o  (idx8),
      .grant_onehot_o (oh8),
      .busy_o         (busy8)
   );

   rv_rr_arbiter #(.N(6)) u6 (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_i          (req6),
      .lock_i         (lock6),
      .unlock_i       (unlock6),
      .grant_ready_i  (ready6),
      .grant_valid_o  (v6),
      .grant_index_o  (idx6),
      .grant_onehot_o (oh6),
      .busy_o         (busy6)
   );

   typedef struct packed {
      logic       valid;
      logic       busy;
      logic [2:0] idx;
      logic [7:0] oh;
   } exp_t;

   typedef struct {
      string      name;
      logic [7:0] req;
      logic       lock;
      logic       unlock;
      logic       ready;
      exp_t       exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t mk(input logic v, input logic b,
                               input logic [2:0] i, input logic [7:0] o);
      exp_t e;
      e.valid = v;
      e.busy  = b;
      e.idx   = i;
      e.oh    = o;
      return e;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got valid=%b busy=%b idx=%0d onehot=%h, want valid=%b busy=%b idx=%0d onehot=%h",
                  name, act.valid, act.busy, act.idx, act.oh,
                  exp.valid, exp.busy, exp.idx, exp.oh);
      end
   endtask

   task automatic addv(input string n, input logic [7:0] r, input logic l,
                       input logic u, input logic rd, input logic ev,
                       input logic eb, input logic [2:0] ei, input logic [7:0] eo);
      vec_t v;
      v.name   = n;
      v.req    = r;
      v.lock   = l;
      v.unlock = u;
      v.ready  = rd;
      v.exp    = mk(ev, eb, ei, eo);
      vecs.push_back(v);
   endtask

   // Drive one cycle on the N=8 instance and score it after the edge.
   task automatic step8(input vec_t v);
      exp_t got;
      req8    = v.req;
      lock8   = v.lock;
      unlock8 = v.unlock;
      ready8  = v.ready;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
      got = mk(v8, busy8, idx8, oh8);
      check(v.name, got, sb_q.pop_front());
   endtask

   // Drive one cycle on the N=6 instance (no lock/unlock used there).
   task automatic step6(input string n, input logic [5:0] r, input logic rd,
                        input exp_t e);
      exp_t got;
      req6   = r;
      ready6 = rd;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = mk(v6, busy6, idx6, {2'b00, oh6});
      check(n, got, sb_q.pop_front());
   endtask

   // Hard stop in case anything stalls the stimulus process.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx;
      vec_t v;

      reset_n = 1'b0;
      req8 = '0; lock8 = 1'b0; unlock8 = 1'b0; ready8 = 1'b0;
      req6 = '0; lock6 = 1'b0; unlock6 = 1'b0; ready6 = 1'b0;

      // ---- vector table for the N=8 instance --------------------------------
      //    name               req    lk un rdy  v  b idx onehot
      addv("single_req",       8'h10, 0, 0, 0,   1, 0, 4, 8'h10);
      addv("single_drop",      8'h00, 0, 0, 1,   0, 0, 4, 8'h00); // ptr -> 5
      addv("ptr_after_drop",   8'hFF, 0, 0, 0,   1, 0, 5, 8'h20);
      for (int k = 1; k <= 9; k++) begin
         idx = (5 + k) % 8;
         addv("rotate", 8'hFF, 0, 0, 1, 1, 0, 3'(idx), 8'(1) << idx);
      end
      addv("rot_drop",         8'h00, 0, 0, 1,   0, 0, 6, 8'h00); // ptr -> 7
      addv("bp_first",         8'h06, 0, 0, 0,   1, 0, 1, 8'h02);
      addv("bp_hold_lockign",  8'h06, 1, 0, 0,   1, 0, 1, 8'h02);
      addv("bp_hold_reqchg",   8'h04, 0, 0, 0,   1, 0, 1, 8'h02);
      addv("bp_hold_reqchg",   8'h04, 0, 0, 0,   1, 0, 1, 8'h02);
      addv("bp_hold_lockign",  8'h04, 1, 0, 0,   1, 0, 1, 8'h02);
      addv("bp_release",       8'h04, 0, 0, 1,   1, 0, 2, 8'h04);
      addv("bp_drop",          8'h00, 0, 0, 1,   0, 0, 2, 8'h00); // ptr -> 3
      addv("idle_no_req",      8'h00, 0, 0, 0,   0, 0, 2, 8'h00);
      addv("lock_offer",       8'h18, 0, 0, 0,   1, 0, 3, 8'h08);
      addv("unlock_in_offer",  8'h18, 0, 1, 0,   1, 0, 3, 8'h08);
      addv("lock_take",        8'h18, 1, 0, 1,   0, 1, 3, 8'h08);
      addv("locked_hold",      8'h18, 0, 0, 1,   0, 1, 3, 8'h08);
      addv("locked_hold",      8'h18, 1, 0, 1,   0, 1, 3, 8'h08);
      addv("unlock",           8'h18, 0, 1, 1,   0, 0, 3, 8'h00); // ptr -> 4
      addv("after_unlock",     8'h18, 0, 0, 0,   1, 0, 4, 8'h10);
      addv("relock",           8'h18, 1, 0, 1,   0, 1, 4, 8'h10);

      // ---- reset state ------------------------------------------------------
      #12;
      check("reset_state8", mk(v8, busy8, idx8, oh8), mk(0, 0, 0, 8'h00));
      check("reset_state6", mk(v6, busy6, idx6, {2'b00, oh6}), mk(0, 0, 0, 8'h00));
      reset_n = 1'b1;

      foreach (vecs[i]) step8(vecs[i]);

      // ---- async reset while LOCKED, released before the next edge ----------
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_locked", mk(v8, busy8, idx8, oh8), mk(0, 0, 0, 8'h00));
      #2 reset_n = 1'b1;

      v.lock = 1'b0; v.unlock = 1'b0;
      v.name = "post_reset_grant"; v.req = 8'h81; v.ready = 1'b0;
      v.exp  = mk(1, 0, 0, 8'h01);
      step8(v);
      v.name = "post_reset_next"; v.req = 8'h81; v.ready = 1'b1;
      v.exp  = mk(1, 0, 7, 8'h80);
      step8(v);
      v.name = "post_reset_drop"; v.req = 8'h00; v.ready = 1'b1;
      v.exp  = mk(0, 0, 7, 8'h00);
      step8(v);

      // ---- N=6: pointer wrap and skip ---------------------------------------
      step6("n6_grant4",   6'b010000, 1'b0, mk(1, 0, 4, 8'h10));
      step6("n6_drop",     6'b000000, 1'b1, mk(0, 0, 4, 8'h00)); // ptr -> 5
      step6("n6_wrap0",    6'b000101, 1'b0, mk(1, 0, 0, 8'h01));
      step6("n6_skip2",    6'b000101, 1'b1, mk(1, 0, 2, 8'h04));
      step6("n6_back0",    6'b000101, 1'b1, mk(1, 0, 0, 8'h01));
      step6("n6_grant5",   6'b100000, 1'b1, mk(1, 0, 5, 8'h20));
      step6("n6_ptr_wrap", 6'b000001, 1'b1, mk(1, 0, 0, 8'h01));
      step6("n6_idle",     6'b000000, 1'b1, mk(0, 0, 0, 8'h00));

      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
